// File: rtl/cpu_pio_pkg.sv
// Shared definitions for the CPU PIO slaves: register offsets and edge-capture encodings.
package cpu_pio_pkg;

   localparam logic [1:0] PIO_DATA     = 2'd0;
   localparam logic [1:0] PIO_RSVD     = 2'd1;
   localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
   localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

   localparam logic [1:0] EDGE_RISE = 2'd0;
   localparam logic [1:0] EDGE_FALL = 2'd1;
   localparam logic [1:0] EDGE_ANY  = 2'd2;

endpackage

// File: rtl/cpu_pio_edge_sync.sv
// Two-flop input synchroniser plus history flop; emits the synchronised value and
// a one-cycle pulse per bit for the configured edge type.
module cpu_pio_edge_sync
   import cpu_pio_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter logic [1:0]  EDGE_TYPE = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_data,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] s3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync_data = s2;

   always_comb begin
      edge_pulse = '0;
      case (EDGE_TYPE)
         EDGE_RISE: edge_pulse = s2 & ~s3;
         EDGE_FALL: edge_pulse = ~s2 & s3;
         default:   edge_pulse = s2 ^ s3;
      endcase
   end

endmodule

// File: rtl/cpu_key_pio.sv
// Avalon-MM input PIO: synchronised DATA, IRQ_MASK, sticky W1C EDGE_CAPTURE and
// a level interrupt for enabled captured edges.
module cpu_key_pio
   import cpu_pio_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter logic [1:0]  EDGE_TYPE = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_data;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] clr_bits;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             unused_wr;

   cpu_pio_edge_sync #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .sync_data  (sync_data),
      .edge_pulse (edge_pulse)
   );

   assign wr_en     = chipselect & ~write_n;
   assign unused_wr = ^writedata;

   always_comb begin
      mask_next = irq_mask;
      clr_bits  = '0;
      rd_next   = '0;
      if (wr_en && address == PIO_IRQ_MASK) mask_next = writedata[WIDTH-1:0];
      if (wr_en && address == PIO_EDGE_CAP) clr_bits  = writedata[WIDTH-1:0];
      case (address)
         PIO_DATA:     rd_next[WIDTH-1:0] = sync_data;
         PIO_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
         PIO_EDGE_CAP: rd_next[WIDTH-1:0] = edge_cap;
         default:      rd_next = '0;
      endcase
   end

   // OR-ing the pulse in after the clear makes a coincident edge win over W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
         readdata <= '0;
      end else begin
         irq_mask <= mask_next;
         edge_cap <= (edge_cap & ~clr_bits) | edge_pulse;
         readdata <= rd_next;
      end
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_cpu_key_pio.sv
// Scoreboard bench: three PIO instances (rise/fall/any) share the bus and inputs and
// are checked each cycle against a sample-history reference model.
module tb_cpu_key_pio;

   typedef struct {
      int          due;
      int unsigned dut;
      logic        is_irq;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   exp_t sb[$];

   logic [3:0] hist[$];
   logic [3:0] m_mask[3];
   logic [3:0] m_cap[3];

   always #5 clk = ~clk;

   cpu_key_pio #(.WIDTH(4), .EDGE_TYPE(2'd0)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
   cpu_key_pio #(.WIDTH(4), .EDGE_TYPE(2'd1)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
   cpu_key_pio #(.WIDTH(4), .EDGE_TYPE(2'd2)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

   function automatic logic [3:0] edges_of(int unsigned kind, logic [3:0] now, logic [3:0] prev);
      case (kind)
         0:       return now & ~prev;
         1:       return ~now & prev;
         default: return now ^ prev;
      endcase
   endfunction

   function automatic logic [31:0] dut_out(int unsigned d, logic is_irq);
      case (d)
         0:       return is_irq ? {31'd0, irq0} : rd0;
         1:       return is_irq ? {31'd0, irq1} : rd1;
         default: return is_irq ? {31'd0, irq2} : rd2;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
   endtask

   // Reference model: hist[k] is the in_port value sampled k edges ago (hist[0] = this edge).
   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         hist = '{4'h0, 4'h0, 4'h0, 4'h0};
         for (int unsigned d = 0; d < 3; d++) begin
            m_mask[d] = '0;
            m_cap[d]  = '0;
         end
      end else begin
         logic        wr;
         logic [3:0]  clr;
         logic [31:0] exp_rd;
         hist.push_front(in_port);
         void'(hist.pop_back());
         wr = chipselect && !write_n;
         for (int unsigned d = 0; d < 3; d++) begin
            exp_rd = '0;
            case (address)
               2'd0: exp_rd[3:0] = hist[2];
               2'd2: exp_rd[3:0] = m_mask[d];
               2'd3: exp_rd[3:0] = m_cap[d];
               default: exp_rd = '0;
            endcase
            sb.push_back('{cyc, d, 1'b0, exp_rd});
            clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
            if (wr && address == 2'd2) m_mask[d] = writedata[3:0];
            m_cap[d] = (m_cap[d] & ~clr) | edges_of(d, hist[2], hist[3]);
            sb.push_back('{cyc, d, 1'b1, {31'd0, |(m_cap[d] & m_mask[d])}});
         end
      end
   end

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due != cyc) check("stale_entry", 32'(e.due), 32'(cyc));
         else check(e.is_irq ? $sformatf("irq[%0d]", e.dut) : $sformatf("readdata[%0d]", e.dut),
                    dut_out(e.dut, e.is_irq), e.val);
      end
   end

   task automatic op(input logic [1:0] a, input logic w, input logic [31:0] d, input logic [3:0] p);
      address    = a;
      chipselect = 1'b1;
      write_n    = !w;
      writedata  = d;
      in_port    = p;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [1:0] a, input logic [3:0] p, input int n);
      for (int i = 0; i < n; i++) op(a, 1'b0, 32'h0, p);
   endtask

   task automatic async_reset(input logic [3:0] p);
      #2;
      reset_n = 1'b0;
      in_port = p;
      sb.delete();
      #1;
      check("async_rd0", rd0, 32'h0);
      check("async_rd1", rd1, 32'h0);
      check("async_rd2", rd2, 32'h0);
      check("async_irq", {29'd0, irq0, irq1, irq2}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_irq", {29'd0, irq0, irq1, irq2}, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) op(2'(i), 1'b0, 32'h0, 4'h0);

      // Mask 5, single rising input, then W1C and a masked edge.
      op(2'd2, 1'b1, 32'h5, 4'h0);
      hold(2'd0, 4'h1, 4);
      hold(2'd3, 4'h1, 2);
      op(2'd3, 1'b1, 32'h1, 4'h1);
      hold(2'd3, 4'h3, 5);
      op(2'd3, 1'b1, 32'hF, 4'h3);
      hold(2'd3, 4'h3, 2);

      // Collision: input sampled at edge N, W1C lands at edge N+2.
      op(2'd3, 1'b0, 32'h0, 4'h2);
      op(2'd0, 1'b0, 32'h0, 4'h2);
      op(2'd3, 1'b1, 32'h1, 4'h2);
      hold(2'd3, 4'h2, 2);

      // Falling-edge instance: F->7 then 7->F.
      hold(2'd0, 4'hF, 4);
      op(2'd3, 1'b1, 32'hF, 4'hF);
      hold(2'd3, 4'h7, 4);
      hold(2'd3, 4'hF, 4);

      async_reset(4'hF);
      hold(2'd3, 4'hF, 5);

      for (int i = 0; i < 400; i++) begin
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom);
         write_n    = 1'($urandom);
         writedata  = $urandom;
         if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
         @(posedge clk);
         #1;
      end

      async_reset(4'h0);
      hold(2'd0, 4'h0, 3);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
